// File: rtl/writeback_buffer.sv
// Write-back queue in front of the register file: accepts results, drains one per cycle
// into the write port, and forwards the youngest still-pending value for rs/rt.
module writeback_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        writeReg,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    output logic                     rs_hit,
    output logic [DATA_W-1:0]        rs_fwd,
    output logic                     rt_hit,
    output logic [DATA_W-1:0]        rt_fwd,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][ADDR_W-1:0] reg_mem_r;
    logic [DEPTH-1:0][DATA_W-1:0] data_mem_r;
    logic [DEPTH-1:0]             valid_r;
    logic [PTR_W-1:0]             wr_ptr_r;
    logic [PTR_W-1:0]             rd_ptr_r;
    logic [CNT_W-1:0]             count_r;

    logic                         in_ready_s;
    logic                         push_s;
    logic                         pop_s;
    logic [ADDR_W-1:0]            head_reg_s;
    logic [DATA_W-1:0]            head_data_s;
    logic [DATA_W:0]              rs_lookup_s;
    logic [DATA_W:0]              rt_lookup_s;

    // Scan oldest to youngest so the last match seen is the youngest pending write.
    function automatic logic [DATA_W:0] fwd_lookup(
        input logic [ADDR_W-1:0]             src,
        input logic [PTR_W-1:0]              rd_ptr,
        input logic [DEPTH-1:0]              vld,
        input logic [DEPTH-1:0][ADDR_W-1:0]  regs,
        input logic [DEPTH-1:0][DATA_W-1:0]  datas
    );
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;
        hit  = 1'b0;
        data = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (vld[idx] && (regs[idx] == src) && (src != {ADDR_W{1'b0}})) begin
                hit  = 1'b1;
                data = datas[idx];
            end else begin
                hit  = hit;
                data = data;
            end
        end
        return {hit, data};
    endfunction

    // Handshake, drain decision and head presentation.
    always_comb begin
        in_ready_s  = (count_r < CNT_W'(DEPTH));
        push_s      = in_valid && in_ready_s && (in_reg != {ADDR_W{1'b0}});
        pop_s       = drain_en && (count_r != {CNT_W{1'b0}});
        head_reg_s  = {ADDR_W{1'b0}};
        head_data_s = {DATA_W{1'b0}};
        if (count_r != {CNT_W{1'b0}}) begin
            head_reg_s  = reg_mem_r[rd_ptr_r];
            head_data_s = data_mem_r[rd_ptr_r];
        end else begin
            head_reg_s  = {ADDR_W{1'b0}};
            head_data_s = {DATA_W{1'b0}};
        end
    end

    // Forwarding looks only at stored entries, never at the incoming result.
    always_comb begin
        rs_lookup_s = fwd_lookup(rs, rd_ptr_r, valid_r, reg_mem_r, data_mem_r);
        rt_lookup_s = fwd_lookup(rt, rd_ptr_r, valid_r, reg_mem_r, data_mem_r);
    end

    // Output mapping.
    always_comb begin
        in_ready  = in_ready_s;
        regWrite  = pop_s;
        writeReg  = head_reg_s;
        writeData = head_data_s;
        rs_hit    = rs_lookup_s[DATA_W];
        rs_fwd    = rs_lookup_s[DATA_W-1:0];
        rt_hit    = rt_lookup_s[DATA_W];
        rt_fwd    = rt_lookup_s[DATA_W-1:0];
        count     = count_r;
    end

    // Queue storage, pointers and occupancy; push and pop never hit the same slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_mem_r  <= '0;
            data_mem_r <= '0;
            valid_r    <= {DEPTH{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                reg_mem_r[wr_ptr_r]  <= in_reg;
                data_mem_r[wr_ptr_r] <= in_data;
                valid_r[wr_ptr_r]    <= 1'b1;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Scoreboard bench for writeback_buffer: a queue of pending writes is the reference model.
module tb_writeback_buffer;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        drain_en;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_hit;
    logic [31:0] rs_fwd;
    logic        rt_hit;
    logic [31:0] rt_fwd;
    logic [2:0]  count;

    ent_t sb_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    logic mon_en = 1'b0;
    logic acc_ok = 1'b1;

    writeback_buffer #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .rs(rs), .rt(rt), .rs_hit(rs_hit), .rs_fwd(rs_fwd),
        .rt_hit(rt_hit), .rt_fwd(rt_fwd), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every observable against the pending-write queue, then retire the head.
    always @(negedge clk) begin
        int          sz;
        logic        eh;
        logic [31:0] ed;
        logic        th;
        logic [31:0] td;
        if (rst && mon_en) begin
            sz = sb_q.size();
            acc_ok = (sz < 4);
            chk("count", 64'(count), 64'(sz));
            chk("in_ready", 64'(in_ready), 64'(sz < 4));
            eh = 1'b0; ed = 32'd0; th = 1'b0; td = 32'd0;
            foreach (sb_q[i]) begin
                if (rs != 5'd0 && sb_q[i].r == rs) begin eh = 1'b1; ed = sb_q[i].d; end
                if (rt != 5'd0 && sb_q[i].r == rt) begin th = 1'b1; td = sb_q[i].d; end
            end
            chk("rs_hit", 64'(rs_hit), 64'(eh));
            chk("rs_fwd", 64'(rs_fwd), 64'(ed));
            chk("rt_hit", 64'(rt_hit), 64'(th));
            chk("rt_fwd", 64'(rt_fwd), 64'(td));
            chk("regWrite", 64'(regWrite), 64'(drain_en && sz != 0));
            chk("writeReg", 64'(writeReg), 64'(sz != 0 ? sb_q[0].r : 5'd0));
            chk("writeData", 64'(writeData), 64'(sz != 0 ? sb_q[0].d : 32'd0));
            if (drain_en && sz != 0) void'(sb_q.pop_front());
        end
    end

    // One clock of stimulus; the offer enters the scoreboard only if the model accepted it.
    task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d, input logic dr);
        in_valid = v; in_reg = r; in_data = d; drain_en = dr;
        @(posedge clk); #1;
        if (v && acc_ok && r != 5'd0) sb_q.push_back('{r, d});
    endtask

    initial begin
        int budget;
        rst = 1'b0; in_valid = 1'b0; in_reg = 5'd0; in_data = 32'd0;
        drain_en = 1'b1; rs = 5'd0; rt = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_regWrite", 64'(regWrite), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_writeData", 64'(writeData), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; mon_en = 1'b1;

        // Single write with one-cycle latency.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        in_valid = 1'b0;
        chk("single_regWrite", 64'(regWrite), 64'd1);
        chk("single_writeReg", 64'(writeReg), 64'd5);
        chk("single_writeData", 64'(writeData), 64'hDEADBEEF);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        chk("single_count", 64'(count), 64'd0);

        // Fill, rejected fifth offer, then in-order drain.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 5'd9, 32'h999, 1'b0);
        chk("full_count_after_offer", 64'(count), 64'd4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1);

        // Forwarding picks the youngest of two writes to the same register.
        rs = 5'd7; rt = 5'd3;
        cycle(1'b1, 5'd7, 32'h11, 1'b0);
        cycle(1'b1, 5'd7, 32'h22, 1'b0);
        in_valid = 1'b0;
        chk("fwd_rs_hit", 64'(rs_hit), 64'd1);
        chk("fwd_rs_fwd", 64'(rs_fwd), 64'h22);
        chk("fwd_rt_hit", 64'(rt_hit), 64'd0);
        chk("fwd_rt_fwd", 64'(rt_fwd), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1);

        // Register zero is accepted but never queued.
        rs = 5'd0;
        cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1);
        in_valid = 1'b0;
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_rs_hit", 64'(rs_hit), 64'd0);

        // Back-to-back stream with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'(1 + i % 31), 32'hA000 + 32'(i), 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 5'd0, 32'd0, 1'b1);

        // Randomized traffic on a small register set to provoke forwarding hits.
        for (int i = 0; i < 400; i++) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 99) < 45));
        end

        // Reset with three entries queued: everything is discarded immediately.
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        rs = 5'd12;
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd12 + 5'(i), 32'hC0 + 32'(i), 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst = 1'b0; drain_en = 1'b1;
        #1;
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_regWrite", 64'(regWrite), 64'd0);
        chk("midrst_rs_hit", 64'(rs_hit), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 1'b1);
        chk("post_rst_regWrite", 64'(regWrite), 64'd0);

        // Final drain with a bounded wait.
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b1);
            budget++;
        end
        chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        chk("final_count", 64'(count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
